// File: rtl/ddr3_burst_writer.sv
// AXI write-side burst master: buffers pre-packed beats in a show-ahead FIFO and
// writes them as fixed-length bursts into a circular DDR3 frame region.
module ddr3_burst_writer #(
    parameter int          DATA_LEN      = 128,
    parameter int          STRB_WIDTH    = 16,
    parameter int          BURST_LEN     = 16,
    parameter int          FIFO_DEPTH    = 64,
    parameter int          ADDR_PER_BEAT = 8,
    parameter logic [27:0] BASE_ADDR     = 28'h0,
    parameter int          FRAME_BEATS   = 115200
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  inited,
    input  logic                  frame_start,
    input  logic [DATA_LEN-1:0]   in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [27:0]           axi_awaddr,
    output logic [3:0]            axi_awlen,
    output logic                  axi_awvalid,
    input  logic                  axi_awready,
    output logic [DATA_LEN-1:0]   axi_wdata,
    output logic [STRB_WIDTH-1:0] axi_wstrb,
    input  logic                  axi_wready,
    input  logic                  axi_wusero_last,
    output logic                  busy,
    output logic                  frame_wrap,
    output logic                  last_err
);

    localparam int               PTR_W      = $clog2(FIFO_DEPTH);
    localparam int               CNT_W      = PTR_W + 1;
    localparam logic [27:0]      BURST_STEP = 28'(BURST_LEN * ADDR_PER_BEAT);
    localparam logic [27:0]      END_ADDR   = BASE_ADDR + 28'(FRAME_BEATS * ADDR_PER_BEAT);
    localparam logic [CNT_W-1:0] BURST_CNT  = CNT_W'(BURST_LEN);
    localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(FIFO_DEPTH);
    localparam logic [4:0]       LAST_BEAT  = 5'(BURST_LEN - 1);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t              state;
    state_t              state_next;
    logic [DATA_LEN-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    fifo_count;
    logic [27:0]         addr;
    logic [27:0]         addr_inc;
    logic [4:0]          beat_cnt;
    logic                start_pending;
    logic                fifo_full;
    logic                push;
    logic                pop;
    logic                last_pop;
    logic                apply_start;
    logic                burst_go;

    assign fifo_full   = (fifo_count == FULL_CNT);
    assign in_ready    = inited && !fifo_full && !start_pending;
    assign push        = in_valid && in_ready;
    assign pop         = (state == DATA) && axi_wready;
    assign last_pop    = pop && (beat_cnt == LAST_BEAT);
    assign apply_start = (state == IDLE) && start_pending;
    assign burst_go    = (state == IDLE) && inited && !start_pending && (fifo_count >= BURST_CNT);
    assign addr_inc    = addr + BURST_STEP;

    assign axi_awaddr  = addr;
    assign axi_awlen   = 4'(BURST_LEN - 1);
    assign axi_awvalid = (state == ADDR);
    assign axi_wdata   = fifo_mem[rd_ptr];
    assign axi_wstrb   = '1;
    assign busy        = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A started burst always runs to completion; inited and frame_start only gate new ones.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (burst_go) state_next = ADDR;
            ADDR:    if (axi_awready) state_next = DATA;
            DATA:    if (last_pop) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= in_data;
        end
    end

    // A pending frame start empties the FIFO in one cycle; push and pop cannot occur then.
    always_ff @(posedge clk) begin
        if (!rstn || apply_start) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            addr          <= BASE_ADDR;
            beat_cnt      <= '0;
            start_pending <= 1'b0;
            frame_wrap    <= 1'b0;
            last_err      <= 1'b0;
        end else begin
            frame_wrap <= 1'b0;
            // A frame_start coinciding with the apply cycle stays pending for the next IDLE.
            if (apply_start) begin
                start_pending <= frame_start;
            end else if (frame_start) begin
                start_pending <= 1'b1;
            end
            if (apply_start) begin
                addr <= BASE_ADDR;
            end else if (last_pop) begin
                if (addr_inc == END_ADDR) begin
                    addr       <= BASE_ADDR;
                    frame_wrap <= 1'b1;
                end else begin
                    addr <= addr_inc;
                end
            end
            if ((state == ADDR) && axi_awready) begin
                beat_cnt <= '0;
            end else if (pop) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
            if (pop && (axi_wusero_last != (beat_cnt == LAST_BEAT))) begin
                last_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ddr3_burst_writer.sv
// Scoreboard bench for ddr3_burst_writer: stimulus queues expected bursts and beats,
// a negedge monitor compares every address and data handshake against them.
module tb_ddr3_burst_writer;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         inited = 1'b0;
    logic         frame_start = 1'b0;
    logic [127:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [27:0]  axi_awaddr;
    logic [3:0]   axi_awlen;
    logic         axi_awvalid;
    logic         axi_awready = 1'b0;
    logic [127:0] axi_wdata;
    logic [15:0]  axi_wstrb;
    logic         axi_wready = 1'b0;
    logic         axi_wusero_last;
    logic         busy;
    logic         frame_wrap;
    logic         last_err;

    int           tests = 0;
    int           fails = 0;
    int           wrap_count = 0;
    int           tb_beat = 0;
    logic         rand_wr = 1'b0;
    logic         wr_level = 1'b0;
    logic         err_inject = 1'b0;
    logic [127:0] exp_data[$];
    logic [27:0]  exp_addr[$];
    logic [127:0] mon_data;
    logic [27:0]  mon_addr;

    ddr3_burst_writer #(
        .DATA_LEN(128), .STRB_WIDTH(16), .BURST_LEN(16), .FIFO_DEPTH(64),
        .ADDR_PER_BEAT(8), .BASE_ADDR(28'h0), .FRAME_BEATS(32)
    ) dut (
        .clk(clk), .rstn(rstn), .inited(inited), .frame_start(frame_start),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awvalid(axi_awvalid),
        .axi_awready(axi_awready), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
        .axi_wready(axi_wready), .axi_wusero_last(axi_wusero_last), .busy(busy),
        .frame_wrap(frame_wrap), .last_err(last_err)
    );

    always #5 clk = ~clk;

    // Controller model: wready is either a steady level or random, and the
    // controller's own beat counter flags the last beat (plus a bogus one on request).
    always @(posedge clk) begin
        #1;
        axi_wready = rand_wr ? 1'($urandom_range(0, 1)) : wr_level;
    end

    always @(posedge clk) begin
        if (!rstn) begin
            tb_beat <= 0;
        end else if (busy && !axi_awvalid && axi_wready) begin
            tb_beat <= (tb_beat == 15) ? 0 : tb_beat + 1;
        end
    end

    always_comb begin
        axi_wusero_last = axi_wready && ((tb_beat == 15) || (err_inject && (tb_beat == 7)));
    end

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Monitor: every handshake the DUT presents is checked against the queues.
    always @(negedge clk) begin
        if (rstn) begin
            if (axi_awvalid && axi_awready) begin
                if (exp_addr.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL aw_unexpected: got addr %0h, required no request", axi_awaddr);
                end else begin
                    mon_addr = exp_addr.pop_front();
                    checkOutput("awaddr", 128'(axi_awaddr), 128'(mon_addr));
                    checkOutput("awlen", 128'(axi_awlen), 128'hF);
                end
            end
            if (busy && !axi_awvalid && axi_wready) begin
                if (exp_data.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL w_unexpected: got wdata %0h, required no beat", axi_wdata);
                end else begin
                    mon_data = exp_data.pop_front();
                    checkOutput("wdata", axi_wdata, mon_data);
                end
            end
            if (frame_wrap) wrap_count++;
        end
    end

    task automatic pushBeat(input logic [127:0] d);
        int guard = 0;
        @(posedge clk);
        #1;
        in_data  = d;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("[TB] FAIL in_ready_timeout: got in_ready 0, required 1");
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            exp_data.push_back(d);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic applyStimulus(input logic [127:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            pushBeat(first + 128'(i));
        end
    endtask

    task automatic waitDrain(input int leftover);
        int  guard = 0;
        logic done = 1'b0;
        while (!done && guard < 3000) begin
            @(negedge clk);
            #1;
            guard++;
            done = (exp_addr.size() == 0) && (exp_data.size() <= leftover) && !busy;
        end
        if (!done) begin
            tests++;
            fails++;
            $display("[TB] FAIL drain_timeout: got %0d bursts / %0d beats outstanding, required 0 / %0d",
                     exp_addr.size(), exp_data.size(), leftover);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int lat;

        // Reset state
        waitCycles(3);
        rstn = 1'b1;
        @(negedge clk);
        checkOutput("rst_awvalid", 128'(axi_awvalid), 128'h0);
        checkOutput("rst_in_ready", 128'(in_ready), 128'h0);
        checkOutput("rst_busy", 128'(busy), 128'h0);
        checkOutput("rst_frame_wrap", 128'(frame_wrap), 128'h0);
        checkOutput("rst_last_err", 128'(last_err), 128'h0);
        checkOutput("rst_awaddr", 128'(axi_awaddr), 128'h0);
        checkOutput("rst_wstrb", 128'(axi_wstrb), 128'hFFFF);

        // One burst at the base address, wready held high
        @(posedge clk);
        #1;
        inited      = 1'b1;
        axi_awready = 1'b1;
        wr_level    = 1'b1;
        @(negedge clk);
        checkOutput("inited_in_ready", 128'(in_ready), 128'h1);
        exp_addr.push_back(28'd0);
        applyStimulus(128'd0, 16);
        waitDrain(0);
        checkOutput("t1_next_awaddr", 128'(axi_awaddr), 128'd128);

        // 15 beats must not start a burst; the 16th raises awvalid two cycles later
        exp_addr.push_back(28'd128);
        applyStimulus(128'd16, 15);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("t2_no_awvalid", 128'(axi_awvalid), 128'h0);
        end
        pushBeat(128'd31);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!axi_awvalid && lat < 20);
        checkOutput("t2_latency", 128'(lat), 128'd2);
        waitDrain(0);
        checkOutput("t2_wrap_addr", 128'(axi_awaddr), 128'd0);
        checkOutput("t2_wrap_count", 128'(wrap_count), 128'd1);

        // 48 beats over a 32-beat frame: 0, 128, then wrap back to 0
        exp_addr.push_back(28'd0);
        exp_addr.push_back(28'd128);
        exp_addr.push_back(28'd0);
        applyStimulus(128'd32, 48);
        waitDrain(0);
        checkOutput("t3_wrap_count", 128'(wrap_count), 128'd2);
        checkOutput("t3_awaddr", 128'(axi_awaddr), 128'd128);

        // awready stalled 10 cycles with random wready
        @(posedge clk);
        #1;
        axi_awready = 1'b0;
        rand_wr     = 1'b1;
        exp_addr.push_back(28'd128);
        applyStimulus(128'd80, 16);
        lat = 0;
        while (!axi_awvalid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("t5_awvalid_hold", 128'(axi_awvalid), 128'h1);
            checkOutput("t5_awaddr_hold", 128'(axi_awaddr), 128'd128);
        end
        @(posedge clk);
        #1;
        axi_awready = 1'b1;
        waitDrain(0);
        rand_wr = 1'b0;
        checkOutput("t5_wrap_count", 128'(wrap_count), 128'd3);
        checkOutput("t5_awaddr", 128'(axi_awaddr), 128'd0);

        // frame_start mid-burst with 5 residual beats
        wr_level = 1'b0;
        exp_addr.push_back(28'd0);
        applyStimulus(128'd100, 21);
        lat = 0;
        while (!(busy && !axi_awvalid) && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        @(posedge clk);
        #1;
        frame_start = 1'b1;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        @(negedge clk);
        checkOutput("t4_in_ready_pending", 128'(in_ready), 128'h0);
        checkOutput("t4_busy_hold", 128'(busy), 128'h1);
        wr_level = 1'b1;
        waitDrain(5);
        checkOutput("t4_residue", 128'(exp_data.size()), 128'd5);
        exp_data.delete();
        checkOutput("t4_in_ready_before_apply", 128'(in_ready), 128'h0);
        @(negedge clk);
        checkOutput("t4_base_addr", 128'(axi_awaddr), 128'd0);
        checkOutput("t4_in_ready_after", 128'(in_ready), 128'h1);
        exp_addr.push_back(28'd0);
        applyStimulus(128'd200, 16);
        waitDrain(0);
        checkOutput("t4_awaddr", 128'(axi_awaddr), 128'd128);
        checkOutput("t4_wrap_count", 128'(wrap_count), 128'd3);

        // Fill the FIFO while the address channel is blocked
        @(posedge clk);
        #1;
        axi_awready = 1'b0;
        exp_addr.push_back(28'd128);
        exp_addr.push_back(28'd0);
        exp_addr.push_back(28'd128);
        exp_addr.push_back(28'd0);
        applyStimulus(128'd300, 64);
        @(negedge clk);
        checkOutput("t6_full_in_ready", 128'(in_ready), 128'h0);
        @(posedge clk);
        #1;
        axi_awready = 1'b1;
        waitDrain(0);
        checkOutput("t6_wrap_count", 128'(wrap_count), 128'd5);
        checkOutput("t6_last_err_clean", 128'(last_err), 128'h0);

        // Spurious last flag on beat 7
        err_inject = 1'b1;
        exp_addr.push_back(28'd128);
        applyStimulus(128'd400, 16);
        waitDrain(0);
        err_inject = 1'b0;
        checkOutput("t7_last_err", 128'(last_err), 128'h1);
        checkOutput("t7_wrap_count", 128'(wrap_count), 128'd6);
        waitCycles(5);
        checkOutput("t7_last_err_sticky", 128'(last_err), 128'h1);
        rstn = 1'b0;
        waitCycles(2);
        @(negedge clk);
        checkOutput("t7_last_err_reset", 128'(last_err), 128'h0);
        checkOutput("t7_busy_reset", 128'(busy), 128'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no end of stimulus, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
